// File: rtl/dm_bus_arbiter.sv
// Two-requester round-robin arbiter in front of the debug-module memory bus.
// Writes complete in the grant cycle; reads hold the bus one extra cycle for the data return.
module dm_bus_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [1:0]                     m_req_i,
  input  logic [1:0]                     m_we_i,
  input  logic [1:0][ADDR_WIDTH-1:0]     m_addr_i,
  input  logic [1:0][DATA_WIDTH/8-1:0]   m_be_i,
  input  logic [1:0][DATA_WIDTH-1:0]     m_wdata_i,
  output logic [1:0]                     m_gnt_o,
  output logic [1:0]                     m_rvalid_o,
  output logic [DATA_WIDTH-1:0]          m_rdata_o,
  output logic                           device_req_o,
  output logic                           device_we_o,
  output logic [ADDR_WIDTH-1:0]          device_addr_o,
  output logic [DATA_WIDTH/8-1:0]        device_be_o,
  output logic [DATA_WIDTH-1:0]          device_wdata_o,
  input  logic [DATA_WIDTH-1:0]          device_rdata_i
);

  typedef enum logic {
    ARB_IDLE      = 1'b0,
    ARB_READ_WAIT = 1'b1
  } state_t;

  state_t state_reg, state_next;
  logic   prio_reg, prio_next;
  logic   owner_reg, owner_next;
  logic   winner;
  logic   grant_any;
  logic   read_done;

  // prio names the requester favoured on the next contended cycle.
  assign winner    = (m_req_i == 2'b11) ? prio_reg : m_req_i[1];
  assign grant_any = !rst && (state_reg == ARB_IDLE) && (|m_req_i);
  assign read_done = !rst && (state_reg == ARB_READ_WAIT);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      assign m_gnt_o[gi]    = grant_any && (winner == 1'(gi));
      assign m_rvalid_o[gi] = read_done && (owner_reg == 1'(gi));
    end
  endgenerate

  always_comb begin
    state_next     = state_reg;
    prio_next      = prio_reg;
    owner_next     = owner_reg;
    device_req_o   = 1'b0;
    device_we_o    = 1'b0;
    device_addr_o  = '0;
    device_be_o    = '1;
    device_wdata_o = '0;
    m_rdata_o      = '0;

    if (grant_any) begin
      device_req_o   = 1'b1;
      device_we_o    = m_we_i[winner];
      device_addr_o  = m_addr_i[winner];
      device_be_o    = m_be_i[winner];
      device_wdata_o = m_wdata_i[winner];
      prio_next      = ~winner;
      if (!m_we_i[winner]) begin
        state_next = ARB_READ_WAIT;
        owner_next = winner;
      end
    end

    if (read_done) begin
      m_rdata_o  = device_rdata_i;
      state_next = ARB_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ARB_IDLE;
      prio_reg  <= 1'b0;
      owner_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      prio_reg  <= prio_next;
      owner_reg <= owner_next;
    end
  end

endmodule
